// File: rtl/mcpu.sv
// Multi-cycle RV32I/RV32E core with a single valid/ready memory port.
// One instruction in flight: fetch, wait, execute, then optional data request/response.
module mcpu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          NREGS    = 32
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_rdata,
    output logic [31:0] pc,
    output logic        retire,
    output logic        halted,
    output logic        trap
);

    localparam int RW = (NREGS == 16) ? 4 : 5;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    typedef enum logic [2:0] {FETCH, IWAIT, EXEC, MREQ, MWAIT, STOP} state_t;

    state_t      state_q;
    logic [31:0] pc_q, instr_q, addr_q, wdata_q;
    logic        valid_q, we_q, retire_q, halted_q, trap_q;
    logic [3:0]  wstrb_q;
    logic [31:0] rf_q [NREGS];

    logic [6:0]  opcode, f7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rs1_v, rs2_v, pc4;

    assign opcode = instr_q[6:0];
    assign rd     = instr_q[11:7];
    assign f3     = instr_q[14:12];
    assign rs1    = instr_q[19:15];
    assign rs2    = instr_q[24:20];
    assign f7     = instr_q[31:25];

    assign imm_i = {{20{instr_q[31]}}, instr_q[31:20]};
    assign imm_s = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
    assign imm_b = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
    assign imm_u = {instr_q[31:12], 12'b0};
    assign imm_j = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};

    assign rs1_v = (rs1 == 5'd0) ? 32'd0 : rf_q[rs1[RW-1:0]];
    assign rs2_v = (rs2 == 5'd0) ? 32'd0 : rf_q[rs2[RW-1:0]];
    assign pc4   = pc_q + 32'd4;

    logic [31:0] alu_b, alu_res;
    logic        alu_alt, br_taken;

    assign alu_b   = (opcode == OPC_OP) ? rs2_v : imm_i;
    assign alu_alt = f7[5] && ((opcode == OPC_OP) || (f3 == 3'b101));

    always_comb begin
        alu_res = 32'd0;
        case (f3)
            3'b000: alu_res = (opcode == OPC_OP && f7[5]) ? rs1_v - alu_b : rs1_v + alu_b;
            3'b001: alu_res = rs1_v << alu_b[4:0];
            3'b010: alu_res = {31'b0, $signed(rs1_v) < $signed(alu_b)};
            3'b011: alu_res = {31'b0, rs1_v < alu_b};
            3'b100: alu_res = rs1_v ^ alu_b;
            3'b101: alu_res = alu_alt ? $unsigned($signed(rs1_v) >>> alu_b[4:0]) : rs1_v >> alu_b[4:0];
            3'b110: alu_res = rs1_v | alu_b;
            3'b111: alu_res = rs1_v & alu_b;
            default: alu_res = 32'd0;
        endcase
    end

    always_comb begin
        br_taken = 1'b0;
        case (f3)
            3'b000: br_taken = (rs1_v == rs2_v);
            3'b001: br_taken = (rs1_v != rs2_v);
            3'b100: br_taken = ($signed(rs1_v) < $signed(rs2_v));
            3'b101: br_taken = ($signed(rs1_v) >= $signed(rs2_v));
            3'b110: br_taken = (rs1_v < rs2_v);
            3'b111: br_taken = (rs1_v >= rs2_v);
            default: br_taken = 1'b0;
        endcase
    end

    logic        illegal, is_ebreak, is_load, is_store, wb_en, jump;
    logic        use_rs1, use_rs2, use_rd;
    logic [31:0] wb_val, target;

    assign is_ebreak = (instr_q == 32'h0010_0073);

    // Everything not explicitly decoded here (including ebreak/ecall) stays illegal.
    always_comb begin
        illegal  = 1'b1;
        use_rs1  = 1'b0;
        use_rs2  = 1'b0;
        use_rd   = 1'b0;
        wb_en    = 1'b0;
        wb_val   = alu_res;
        jump     = 1'b0;
        target   = pc_q + imm_b;
        is_load  = 1'b0;
        is_store = 1'b0;
        case (opcode)
            OPC_LUI: begin
                illegal = 1'b0; use_rd = 1'b1; wb_en = 1'b1; wb_val = imm_u;
            end
            OPC_AUIPC: begin
                illegal = 1'b0; use_rd = 1'b1; wb_en = 1'b1; wb_val = pc_q + imm_u;
            end
            OPC_JAL: begin
                illegal = 1'b0; use_rd = 1'b1; wb_en = 1'b1; wb_val = pc4;
                jump = 1'b1; target = pc_q + imm_j;
            end
            OPC_JALR: begin
                illegal = (f3 != 3'b000); use_rd = 1'b1; use_rs1 = 1'b1;
                wb_en = 1'b1; wb_val = pc4;
                jump = 1'b1; target = (rs1_v + imm_i) & ~32'd1;
            end
            OPC_BRANCH: begin
                illegal = (f3[2:1] == 2'b01); use_rs1 = 1'b1; use_rs2 = 1'b1;
                jump = br_taken;
            end
            OPC_LOAD: begin
                illegal = (f3 == 3'b011) || (f3[2:1] == 2'b11);
                use_rs1 = 1'b1; use_rd = 1'b1; is_load = 1'b1;
            end
            OPC_STORE: begin
                illegal = f3[2] || (f3 == 3'b011);
                use_rs1 = 1'b1; use_rs2 = 1'b1; is_store = 1'b1;
            end
            OPC_OPIMM: begin
                illegal = ((f3 == 3'b001) && (f7 != 7'h00)) ||
                          ((f3 == 3'b101) && (f7 != 7'h00) && (f7 != 7'h20));
                use_rs1 = 1'b1; use_rd = 1'b1; wb_en = 1'b1;
            end
            OPC_OP: begin
                illegal = !((f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101))));
                use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1; wb_en = 1'b1;
            end
            OPC_FENCE: begin
                illegal = (f3 != 3'b000);
            end
            default: illegal = 1'b1;
        endcase
        if (NREGS == 16 && ((use_rs1 && rs1[4]) || (use_rs2 && rs2[4]) || (use_rd && rd[4])))
            illegal = 1'b1;
    end

    logic [31:0] ls_addr, st_wdata, ld_data, next_pc;
    logic [3:0]  st_wstrb;
    logic        misaligned, bad_target;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign ls_addr    = rs1_v + (is_store ? imm_s : imm_i);
    assign misaligned = ((f3[1:0] == 2'b01) && ls_addr[0]) ||
                        ((f3[1:0] == 2'b10) && (ls_addr[1:0] != 2'b00));
    assign next_pc    = jump ? target : pc4;
    assign bad_target = jump && target[1];

    always_comb begin
        st_wdata = rs2_v;
        st_wstrb = 4'b1111;
        case (f3[1:0])
            2'b00: begin
                st_wdata = {4{rs2_v[7:0]}};
                st_wstrb = 4'b0001 << ls_addr[1:0];
            end
            2'b01: begin
                st_wdata = {2{rs2_v[15:0]}};
                st_wstrb = ls_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_wdata = rs2_v;
                st_wstrb = 4'b1111;
            end
        endcase
    end

    // The load address stays in addr_q after acceptance, so its low bits pick the lane.
    always_comb begin
        ld_byte = 8'd0;
        case (addr_q[1:0])
            2'b00: ld_byte = mem_rsp_rdata[7:0];
            2'b01: ld_byte = mem_rsp_rdata[15:8];
            2'b10: ld_byte = mem_rsp_rdata[23:16];
            default: ld_byte = mem_rsp_rdata[31:24];
        endcase
        ld_half = addr_q[1] ? mem_rsp_rdata[31:16] : mem_rsp_rdata[15:0];
        case (f3)
            3'b000: ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001: ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100: ld_data = {24'd0, ld_byte};
            3'b101: ld_data = {16'd0, ld_half};
            default: ld_data = mem_rsp_rdata;
        endcase
    end

    logic        rf_we;
    logic [31:0] rf_wdata;

    assign rf_we = (rd != 5'd0) &&
                   (((state_q == EXEC) && wb_en && !illegal && !bad_target) ||
                    ((state_q == MWAIT) && mem_rsp_valid));
    assign rf_wdata = (state_q == MWAIT) ? ld_data : wb_val;

    always_ff @(posedge clk) begin
        if (rf_we)
            rf_q[rd[RW-1:0]] <= rf_wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            instr_q  <= 32'd0;
            addr_q   <= RESET_PC;
            wdata_q  <= 32'd0;
            wstrb_q  <= 4'd0;
            valid_q  <= 1'b0;
            we_q     <= 1'b0;
            retire_q <= 1'b0;
            halted_q <= 1'b0;
            trap_q   <= 1'b0;
        end else begin
            retire_q <= 1'b0;
            case (state_q)
                FETCH: begin
                    if (!valid_q) begin
                        valid_q <= 1'b1;
                        addr_q  <= pc_q;
                    end else if (mem_req_ready) begin
                        valid_q <= 1'b0;
                        state_q <= IWAIT;
                    end
                end
                IWAIT: begin
                    if (mem_rsp_valid) begin
                        instr_q <= mem_rsp_rdata;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    if (illegal) begin
                        state_q  <= STOP;
                        halted_q <= 1'b1;
                        trap_q   <= !is_ebreak;
                    end else if ((is_load || is_store) && misaligned) begin
                        state_q  <= STOP;
                        halted_q <= 1'b1;
                        trap_q   <= 1'b1;
                    end else if (is_load || is_store) begin
                        state_q <= MREQ;
                        valid_q <= 1'b1;
                        addr_q  <= ls_addr;
                        we_q    <= is_store;
                        wstrb_q <= is_store ? st_wstrb : 4'd0;
                        wdata_q <= is_store ? st_wdata : 32'd0;
                    end else if (bad_target) begin
                        state_q  <= STOP;
                        halted_q <= 1'b1;
                        trap_q   <= 1'b1;
                    end else begin
                        pc_q     <= next_pc;
                        addr_q   <= next_pc;
                        valid_q  <= 1'b1;
                        retire_q <= 1'b1;
                        state_q  <= FETCH;
                    end
                end
                MREQ: begin
                    if (mem_req_ready) begin
                        we_q    <= 1'b0;
                        wstrb_q <= 4'd0;
                        if (we_q) begin
                            pc_q     <= pc4;
                            addr_q   <= pc4;
                            retire_q <= 1'b1;
                            state_q  <= FETCH;
                        end else begin
                            valid_q <= 1'b0;
                            state_q <= MWAIT;
                        end
                    end
                end
                MWAIT: begin
                    if (mem_rsp_valid) begin
                        pc_q     <= pc4;
                        addr_q   <= pc4;
                        valid_q  <= 1'b1;
                        retire_q <= 1'b1;
                        state_q  <= FETCH;
                    end
                end
                STOP: begin
                    valid_q  <= 1'b0;
                    halted_q <= 1'b1;
                end
                default: state_q <= STOP;
            endcase
        end
    end

    assign mem_req_valid = valid_q;
    assign mem_addr      = addr_q;
    assign mem_we        = we_q;
    assign mem_wstrb     = wstrb_q;
    assign mem_wdata     = wdata_q;
    assign pc            = pc_q;
    assign retire        = retire_q;
    assign halted        = halted_q;
    assign trap          = trap_q;

endmodule

// File: tb/tb_mcpu.sv
// Directed bench for mcpu: a program whose stores expose register results,
// checked against a queue of expected store transactions, plus an RV32E instance.
module tb_mcpu;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b0;
    logic        memReqValid, memReqReady, memWe, memRspValid, retire, halted, trap;
    logic [31:0] memAddr, memWdata, memRspRdata, pc;
    logic [3:0]  memWstrb;

    logic        reqValid16, ready16, we16, rspValid16, retire16, halted16, trap16;
    logic [31:0] addr16, wdata16, rdata16, pc16;
    logic [3:0]  wstrb16;

    initial begin
        memReqReady = 1'b1;
        ready16     = 1'b1;
    end

    mcpu dut (
        .clk(clk), .rst(rst),
        .mem_req_valid(memReqValid), .mem_req_ready(memReqReady),
        .mem_addr(memAddr), .mem_we(memWe), .mem_wstrb(memWstrb), .mem_wdata(memWdata),
        .mem_rsp_valid(memRspValid), .mem_rsp_rdata(memRspRdata),
        .pc(pc), .retire(retire), .halted(halted), .trap(trap)
    );

    mcpu #(.NREGS(16)) dut16 (
        .clk(clk), .rst(rst),
        .mem_req_valid(reqValid16), .mem_req_ready(ready16),
        .mem_addr(addr16), .mem_we(we16), .mem_wstrb(wstrb16), .mem_wdata(wdata16),
        .mem_rsp_valid(rspValid16), .mem_rsp_rdata(rdata16),
        .pc(pc16), .retire(retire16), .halted(halted16), .trap(trap16)
    );

    int testsRun = 0;
    int testsFailed = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] encI(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] encS(input logic [11:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] encR(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    function automatic logic [31:0] encB(input logic [12:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction

    function automatic logic [31:0] encJ(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
    endfunction

    logic [31:0] mem [logic [29:0]];

    function automatic logic [31:0] readWord(input logic [31:0] addr);
        if (mem.exists(addr[31:2]))
            return mem[addr[31:2]];
        return 32'd0;
    endfunction

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] data;
    } store_t;

    store_t expStores[$];

    task automatic expectStore(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] data);
        store_t s;
        s.addr = addr;
        s.strb = strb;
        s.data = data;
        expStores.push_back(s);
    endtask

    // Memory model: samples the request at the edge, answers one cycle after an accepted read.
    int          cycleNo = 0;
    int          retireCount = 0;
    int          lastRetireCycle = 0;
    int          phase = 1;
    logic        saw1001 = 1'b0;
    logic        acceptedRead;
    logic [31:0] readData;
    store_t      gotStore;
    initial begin
        memRspValid = 1'b0;
        memRspRdata = 32'd0;
    end
    always @(posedge clk) begin
        cycleNo++;
        acceptedRead = memReqValid && memReqReady && !memWe;
        readData = readWord(memAddr);
        if (memReqValid && memAddr == 32'h8000_1001)
            saw1001 = 1'b1;
        if (memReqValid && memReqReady && memWe) begin
            if (expStores.size() > 0) begin
                gotStore = expStores.pop_front();
            end else begin
                gotStore.addr = 32'hDEAD_BEEF;
                gotStore.strb = 4'h0;
                gotStore.data = 32'hDEAD_BEEF;
            end
            checkOutput("storeAddr", memAddr, gotStore.addr);
            checkOutput("storeStrb", {28'd0, memWstrb}, {28'd0, gotStore.strb});
            checkOutput("storeData", memWdata, gotStore.data);
        end
        if (retire) begin
            retireCount++;
            if (phase == 1 && retireCount == 2) begin
                checkOutput("retireSpacing", 32'(cycleNo - lastRetireCycle), 32'd3);
                checkOutput("pcAfterAlu", pc, 32'h8000_0008);
            end
            lastRetireCycle = cycleNo;
        end
        #1;
        memRspValid = acceptedRead;
        memRspRdata = acceptedRead ? readData : 32'd0;
    end

    int          retire16Count = 0;
    logic        accepted16;
    logic [31:0] fetch16Addr;
    initial begin
        rspValid16 = 1'b0;
        rdata16    = 32'd0;
    end
    always @(posedge clk) begin
        accepted16  = reqValid16 && ready16 && !we16;
        fetch16Addr = addr16;
        if (retire16)
            retire16Count++;
        #1;
        rspValid16 = accepted16;
        rdata16    = (accepted16 && fetch16Addr == 32'h8000_0000) ? encI(12'd1, 5'd0, 3'd0, 5'd16, 7'h13) : 32'd0;
    end

    task automatic applyStimulus(input int cycles);
        @(negedge clk);
        rst = 1'b0;
        repeat (cycles) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [31:0] prog [27];
        logic        found;
        int          baseRetire;

        prog[0]  = encI(12'd5,   5'd0, 3'd0, 5'd1, 7'h13);
        prog[1]  = encI(12'hFF9, 5'd1, 3'd0, 5'd2, 7'h13);
        prog[2]  = {20'h80001, 5'd3, 7'h37};
        prog[3]  = encS(12'd0,  5'd2,  5'd3, 3'd2);
        prog[4]  = encI(12'h0AB, 5'd0, 3'd0, 5'd2, 7'h13);
        prog[5]  = encS(12'd3,  5'd2,  5'd3, 3'd0);
        prog[6]  = encI(12'd2,   5'd3, 3'd1, 5'd4, 7'h03);
        prog[7]  = encS(12'd4,  5'd4,  5'd3, 3'd2);
        prog[8]  = encI(12'h7FF, 5'd0, 3'd0, 5'd5, 7'h13);
        prog[9]  = encS(12'd6,  5'd5,  5'd3, 3'd1);
        prog[10] = encI(12'd3,   5'd3, 3'd0, 5'd6, 7'h03);
        prog[11] = encI(12'd3,   5'd3, 3'd4, 5'd7, 7'h03);
        prog[12] = encR(7'h00, 5'd7, 5'd6, 3'd2, 5'd8);
        prog[13] = encR(7'h00, 5'd7, 5'd6, 3'd3, 5'd9);
        prog[14] = encR(7'h20, 5'd6, 5'd7, 3'd0, 5'd10);
        prog[15] = encI(12'h004, 5'd10, 3'd1, 5'd11, 7'h13);
        prog[16] = encS(12'd12, 5'd8,  5'd3, 3'd2);
        prog[17] = encS(12'd16, 5'd9,  5'd3, 3'd2);
        prog[18] = encS(12'd20, 5'd11, 5'd3, 3'd2);
        prog[19] = encB(13'd8, 5'd7, 5'd6, 3'd4);
        prog[20] = encS(12'd24, 5'd0,  5'd3, 3'd2);
        prog[21] = encJ(21'd8, 5'd12);
        prog[22] = encS(12'd28, 5'd0,  5'd3, 3'd2);
        prog[23] = encS(12'd32, 5'd12, 5'd3, 3'd2);
        prog[24] = encI(12'h404, 5'd6, 3'd5, 5'd13, 7'h13);
        prog[25] = encS(12'd36, 5'd13, 5'd3, 3'd2);
        prog[26] = encI(12'd1,   5'd3, 3'd2, 5'd14, 7'h03);
        for (int i = 0; i < 27; i++)
            mem[30'(32'h2000_0000 + i)] = prog[i];
        mem[30'h2000_0400] = 32'h8001_0000;

        expectStore(32'h8000_1000, 4'b1111, 32'hFFFF_FFFE);
        expectStore(32'h8000_1003, 4'b1000, 32'hABAB_ABAB);
        expectStore(32'h8000_1004, 4'b1111, 32'hFFFF_8001);
        expectStore(32'h8000_1006, 4'b1100, 32'h07FF_07FF);
        expectStore(32'h8000_100C, 4'b1111, 32'h0000_0001);
        expectStore(32'h8000_1010, 4'b1111, 32'h0000_0000);
        expectStore(32'h8000_1014, 4'b1111, 32'h0000_1000);
        expectStore(32'h8000_1020, 4'b1111, 32'h8000_0058);
        expectStore(32'h8000_1024, 4'b1111, 32'hFFFF_FFF8);

        repeat (3) @(negedge clk);
        checkOutput("resetValid", {31'd0, memReqValid}, 32'd0);
        checkOutput("resetHalted", {31'd0, halted}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("firstFetchValid", {31'd0, memReqValid}, 32'd1);
        checkOutput("firstFetchAddr", memAddr, 32'h8000_0000);
        checkOutput("firstFetchHalted", {31'd0, halted}, 32'd0);

        // Stall the lh data request for five cycles and watch it hold still.
        found = 1'b0;
        for (int i = 0; i < 500 && !found; i++) begin
            @(negedge clk);
            if (memReqValid && memAddr == 32'h8000_1002)
                found = 1'b1;
        end
        checkOutput("lhRequestSeen", {31'd0, found}, 32'd1);
        memReqReady = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("stallValid", {31'd0, memReqValid}, 32'd1);
            checkOutput("stallAddr", memAddr, 32'h8000_1002);
            checkOutput("stallWe", {31'd0, memWe}, 32'd0);
        end
        memReqReady = 1'b1;

        for (int i = 0; i < 2000 && !halted; i++)
            @(negedge clk);
        checkOutput("misalignHalted", {31'd0, halted}, 32'd1);
        checkOutput("misalignTrap", {31'd0, trap}, 32'd1);
        checkOutput("misalignPc", pc, 32'h8000_0068);
        checkOutput("stopValid", {31'd0, memReqValid}, 32'd0);
        checkOutput("noMisalignedReq", {31'd0, saw1001}, 32'd0);
        checkOutput("retireTotal", 32'(retireCount), 32'd24);
        checkOutput("storesLeft", 32'(expStores.size()), 32'd0);

        checkOutput("rv32eHalted", {31'd0, halted16}, 32'd1);
        checkOutput("rv32eTrap", {31'd0, trap16}, 32'd1);
        checkOutput("rv32eRetires", 32'(retire16Count), 32'd0);

        mem[30'h2000_0000] = 32'h0010_0073;
        phase = 2;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("asyncHalted", {31'd0, halted}, 32'd0);
        checkOutput("asyncTrap", {31'd0, trap}, 32'd0);
        checkOutput("asyncValid", {31'd0, memReqValid}, 32'd0);
        checkOutput("asyncWe", {31'd0, memWe}, 32'd0);
        checkOutput("asyncWstrb", {28'd0, memWstrb}, 32'd0);
        checkOutput("asyncPc", pc, 32'h8000_0000);
        baseRetire = retireCount;
        applyStimulus(3);
        for (int i = 0; i < 200 && !halted; i++)
            @(negedge clk);
        checkOutput("ebreakHalted", {31'd0, halted}, 32'd1);
        checkOutput("ebreakTrap", {31'd0, trap}, 32'd0);
        checkOutput("ebreakPc", pc, 32'h8000_0000);
        checkOutput("ebreakNoRetire", 32'(retireCount - baseRetire), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
